level_unpacker: RTL and testbench

Upstream feeder for the dequantizer stage. Takes a stream of 32-bit words carrying packed signed quantization levels (4/8/16/32 bits each). Sign-extends each level to 32 bits and presents them one per beat as level_int/is_weight, with a valid/ready handshake. Runs one tensor per start command; the level count comes from the config.

---
 rtl/level_unpack_pkg.sv | 26 ++
 rtl/level_lane_extract.sv | 30 +++
 rtl/level_unpacker.sv | 140 ++++++++++++++
 tb/tb_level_unpacker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_unpack_pkg.sv
// Shared definitions for the level unpacker: width codes, lane counts and FSM states.
package level_unpack_pkg;

    localparam logic [1:0] WCODE_4  = 2'b00;
    localparam logic [1:0] WCODE_8  = 2'b01;
    localparam logic [1:0] WCODE_16 = 2'b10;
    localparam logic [1:0] WCODE_32 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Levels carried by one 32-bit word for a given width code.
    function automatic logic [3:0] lanes_per_word(input logic [1:0] wcode);
        case (wcode)
            WCODE_4:  return 4'd8;
            WCODE_8:  return 4'd4;
            WCODE_16: return 4'd2;
            default:  return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/level_lane_extract.sv
// Combinational lane select and sign extension of one packed level.
module level_lane_extract
    import level_unpack_pkg::*;
(
    input  logic [31:0]        word,
    input  logic [2:0]         lane,
    input  logic [1:0]         wcode,
    output logic signed [31:0] level
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    always_comb begin
        case (wcode)
            WCODE_4:  shamt = {lane, 2'b00};
            WCODE_8:  shamt = {lane[1:0], 3'b000};
            WCODE_16: shamt = {lane[0], 4'b0000};
            default:  shamt = 5'd0;
        endcase
        shifted = word >> shamt;
        case (wcode)
            WCODE_4:  level = {{28{shifted[3]}}, shifted[3:0]};
            WCODE_8:  level = {{24{shifted[7]}}, shifted[7:0]};
            WCODE_16: level = {{16{shifted[15]}}, shifted[15:0]};
            default:  level = shifted;
        endcase
    end

endmodule

// File: rtl/level_unpacker.sv
// Unpacks 32-bit words of signed 4/8/16/32-bit levels into one level per beat.
// Optional macro LEVEL_UNPACKER_PREFETCH_EN adds a second word buffer for bubble-free throughput.
module level_unpacker
    import level_unpack_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_width,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cfg_is_weight,
    output logic              busy,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       level_int,
    output logic              is_weight,
    output logic              level_valid,
    input  logic              level_ready,
    output logic              done
);

    state_t            state, state_nxt;
    logic [1:0]        width_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              is_weight_q;
    logic [WORD_W-1:0] word_q;
    logic [2:0]        lane_q;
    logic signed [31:0] lane_level;
    logic              level_hs, last_lane, final_beat;

`ifdef LEVEL_UNPACKER_PREFETCH_EN
    logic [WORD_W-1:0] buf_q;
    logic              buf_valid;
`endif

    level_lane_extract u_extract (
        .word  (word_q),
        .lane  (lane_q),
        .wcode (width_q),
        .level (lane_level)
    );

    assign level_valid = (state == ST_EMIT);
    assign level_hs    = level_valid && level_ready;
    assign last_lane   = ({1'b0, lane_q} == lanes_per_word(width_q) - 4'd1);
    assign final_beat  = (remaining_q == CNT_W'(1));
    assign busy        = (state == ST_LOAD) || (state == ST_EMIT);
    assign done        = (state == ST_DONE);
    assign is_weight   = is_weight_q;
    assign level_int   = level_valid ? lane_level : 32'd0;

`ifdef LEVEL_UNPACKER_PREFETCH_EN
    assign in_ready = (state == ST_LOAD) || ((state == ST_EMIT) && !buf_valid);
`else
    assign in_ready = (state == ST_LOAD);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (cfg_count == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD: if (in_valid) state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (level_hs) begin
                    if (final_beat) state_nxt = ST_DONE;
`ifdef LEVEL_UNPACKER_PREFETCH_EN
                    else if (last_lane) state_nxt = (buf_valid || in_valid) ? ST_EMIT : ST_LOAD;
`else
                    else if (last_lane) state_nxt = ST_LOAD;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the word and counters are reset as well, so level_int and is_weight read 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_q     <= WCODE_4;
            remaining_q <= '0;
            is_weight_q <= 1'b0;
            word_q      <= '0;
            lane_q      <= '0;
`ifdef LEVEL_UNPACKER_PREFETCH_EN
            buf_q       <= '0;
            buf_valid   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    width_q     <= cfg_width;
                    remaining_q <= cfg_count;
                    is_weight_q <= cfg_is_weight;
                end
                ST_LOAD: if (in_valid) begin
                    word_q <= in_word;
                    lane_q <= '0;
                end
                ST_EMIT: begin
                    if (level_hs) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        lane_q      <= lane_q + 3'd1;
                    end
`ifdef LEVEL_UNPACKER_PREFETCH_EN
                    // On a word boundary take the buffered word, or the incoming one straight through.
                    if (level_hs && last_lane && !final_beat) begin
                        if (buf_valid) begin
                            word_q    <= buf_q;
                            buf_valid <= 1'b0;
                            lane_q    <= '0;
                        end else if (in_valid) begin
                            word_q <= in_word;
                            lane_q <= '0;
                        end
                    end else if (in_valid && !buf_valid) begin
                        buf_q     <= in_word;
                        buf_valid <= 1'b1;
                    end
`endif
                end
                default: begin
`ifdef LEVEL_UNPACKER_PREFETCH_EN
                    buf_valid <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_unpacker.sv
// Scoreboard bench for level_unpacker: expected levels are queued at stimulus time and popped per handshake.
module tb_level_unpacker;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       cfg_width = 2'b00;
    logic [CNT_W-1:0] cfg_count = '0;
    logic             cfg_is_weight = 1'b0;
    logic             busy;
    logic [31:0]      in_word = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      level_int;
    logic             is_weight;
    logic             level_valid;
    logic             level_ready = 1'b1;
    logic             done;

    always #5 clk = ~clk;

    level_unpacker #(.WORD_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_count(cfg_count),
        .cfg_is_weight(cfg_is_weight), .busy(busy), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .level_int(level_int), .is_weight(is_weight),
        .level_valid(level_valid), .level_ready(level_ready), .done(done)
    );

    typedef struct packed {
        logic [31:0] level;
        logic        isw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] wq[$];
    int          beat_cyc[$];
    int n_vec = 0, n_err = 0;
    int cyc = 0, beats = 0, words_taken = 0, in_ready_cycles = 0;
    int stalls_done = 0, stall_target = 0, done_cyc = -1;
    int b0, w0, r0, s0;
    logic word_fire = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v, input logic isw);
        exp_t e;
        e.level = v;
        e.isw   = isw;
        sb.push_back(e);
    endtask

    // Word feeder and level monitor; all DUT sampling happens on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (word_fire) begin
            if (wq.size() > 0) void'(wq.pop_front());
            words_taken++;
        end
        in_valid    = (wq.size() > 0);
        in_word     = in_valid ? wq[0] : 32'd0;
        level_ready = !(level_valid && (stalls_done < stall_target));
        word_fire   = in_valid && in_ready;
        if (in_ready) in_ready_cycles++;
        if (done) done_cyc = cyc;
        if (level_valid && !level_ready) begin
            stalls_done++;
            if (sb.size() > 0) begin
                check("stall_level", level_int, sb[0].level);
                check("stall_is_weight", {31'd0, is_weight}, {31'd0, sb[0].isw});
            end
        end
        if (level_valid && level_ready) begin
            beats++;
            beat_cyc.push_back(cyc);
            if (sb.size() == 0) check("unexpected_level", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("level", level_int, e.level);
                check("is_weight", {31'd0, is_weight}, {31'd0, e.isw});
            end
        end
    end

    task automatic pulse_start(input logic [1:0] w, input int cnt, input logic isw);
        @(negedge clk);
        start = 1'b1;
        cfg_width = w;
        cfg_count = CNT_W'(cnt);
        cfg_is_weight = isw;
        @(negedge clk);
        start = 1'b0;
        cfg_width = 2'($urandom);
        cfg_count = CNT_W'($urandom);
        cfg_is_weight = 1'($urandom);
    endtask

    task automatic start_tensor(input logic [1:0] w, input int cnt, input logic isw);
        b0 = beats;
        w0 = words_taken;
        r0 = in_ready_cycles;
        s0 = stalls_done;
        pulse_start(w, cnt, isw);
    endtask

    task automatic wait_done(input string tag, output int waited);
        waited = 0;
        while (!done && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        else begin
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        end
    endtask

    task automatic finish_tensor(input string tag, input int n_beats);
        int waited;
        wait_done(tag, waited);
        @(negedge clk);
        check({tag, "_beats"}, beats - b0, n_beats);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_words_left"}, wq.size(), 0);
    endtask

    task automatic wait_level_valid(input string tag);
        int n = 0;
        while (!level_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!level_valid) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic int span();
        return beat_cyc[beat_cyc.size() - 1] - beat_cyc[b0];
    endfunction

    initial begin
        int waited;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_level_valid", {31'd0, level_valid}, 32'd0);
        check("rst_level_int", level_int, 32'd0);
        check("rst_is_weight", {31'd0, is_weight}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit levels from one word, LSB lane first
        wq.push_back(32'h80FF017F);
        push_exp(32'd127, 1'b1);
        push_exp(32'd1, 1'b1);
        push_exp(32'hFFFFFFFF, 1'b1);
        push_exp(32'hFFFFFF80, 1'b1);
        start_tensor(2'b01, 4, 1'b1);
        check("t1_busy_load", {31'd0, busy}, 32'd1);
        check("t1_in_ready_load", {31'd0, in_ready}, 32'd1);
        finish_tensor("t1", 4);
        check("t1_words", words_taken - w0, 1);
        check("t1_span", span(), 3);
        check("t1_done_after_last", done_cyc - beat_cyc[beat_cyc.size() - 1], 1);

        // 4-bit levels, tensor ends mid-word
        wq.push_back(32'h00000F87);
        push_exp(32'd7, 1'b0);
        push_exp(32'hFFFFFFF8, 1'b0);
        push_exp(32'hFFFFFFFF, 1'b0);
        start_tensor(2'b00, 3, 1'b0);
        finish_tensor("t2", 3);
        check("t2_words", words_taken - w0, 1);
`ifndef LEVEL_UNPACKER_PREFETCH_EN
        check("t2_in_ready_cycles", in_ready_cycles - r0, 1);
`endif

        // 16-bit levels across two words
        wq.push_back(32'h38E2FFFF);
        wq.push_back(32'h00001000);
        push_exp(32'hFFFFFFFF, 1'b1);
        push_exp(32'h000038E2, 1'b1);
        push_exp(32'h00001000, 1'b1);
        start_tensor(2'b10, 3, 1'b1);
        finish_tensor("t3", 3);
        check("t3_words", words_taken - w0, 2);
`ifdef LEVEL_UNPACKER_PREFETCH_EN
        check("t3_span", span(), 2);
`else
        check("t3_span", span(), 3);
`endif
        check("t3_is_weight_latched", {31'd0, is_weight}, 32'd1);

        // 32-bit levels with backpressure on the first beat
        wq.push_back(32'h80000001);
        wq.push_back(32'h7FFFFFFE);
        push_exp(32'h80000001, 1'b0);
        push_exp(32'h7FFFFFFE, 1'b0);
        stall_target = stalls_done + 3;
        start_tensor(2'b11, 2, 1'b0);
        finish_tensor("t4", 2);
        check("t4_stall_cycles", stalls_done - s0, 3);

        // empty tensor
        start_tensor(2'b01, 0, 1'b1);
        check("t5a_done_next", {31'd0, done}, 32'd1);
        check("t5a_in_ready", {31'd0, in_ready}, 32'd0);
        wait_done("t5a", waited);
        check("t5a_waited", waited, 0);
        check("t5a_in_ready_cycles", in_ready_cycles - r0, 0);
        check("t5a_beats", beats - b0, 0);
        check("t5a_is_weight", {31'd0, is_weight}, 32'd1);

        // start pulse during EMIT is ignored
        wq.push_back(32'h00000011);
        wq.push_back(32'hFFFFFF22);
        wq.push_back(32'h12345678);
        push_exp(32'h00000011, 1'b1);
        push_exp(32'hFFFFFF22, 1'b1);
        push_exp(32'h12345678, 1'b1);
        stall_target = stalls_done + 4;
        start_tensor(2'b11, 3, 1'b1);
        wait_level_valid("t5b");
        pulse_start(2'b00, 1, 1'b0);
        finish_tensor("t5b", 3);
        check("t5b_is_weight", {31'd0, is_weight}, 32'd1);

        // reset while emitting
        wq.push_back(32'h04030201);
        push_exp(32'd1, 1'b1);
        push_exp(32'd2, 1'b1);
        push_exp(32'd3, 1'b1);
        push_exp(32'd4, 1'b1);
        stall_target = stalls_done + 1000;
        start_tensor(2'b01, 4, 1'b1);
        wait_level_valid("t5c");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5c_level_valid", {31'd0, level_valid}, 32'd0);
        check("t5c_level_int", level_int, 32'd0);
        check("t5c_busy", {31'd0, busy}, 32'd0);
        check("t5c_in_ready", {31'd0, in_ready}, 32'd0);
        check("t5c_is_weight", {31'd0, is_weight}, 32'd0);
        check("t5c_done", {31'd0, done}, 32'd0);
        sb.delete();
        wq.delete();
        stall_target = stalls_done;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t5c_idle_busy", {31'd0, busy}, 32'd0);
        check("t5c_idle_done", {31'd0, done}, 32'd0);

        // sustained stream of 8-bit levels
        wq.push_back(32'h7C83F211);
        wq.push_back(32'h807F00FF);
        push_exp(32'd17, 1'b0);
        push_exp(32'hFFFFFFF2, 1'b0);
        push_exp(32'hFFFFFF83, 1'b0);
        push_exp(32'd124, 1'b0);
        push_exp(32'hFFFFFFFF, 1'b0);
        push_exp(32'd0, 1'b0);
        push_exp(32'd127, 1'b0);
        push_exp(32'hFFFFFF80, 1'b0);
        start_tensor(2'b01, 8, 1'b0);
        finish_tensor("t6", 8);
        check("t6_words", words_taken - w0, 2);
`ifdef LEVEL_UNPACKER_PREFETCH_EN
        check("t6_span", span(), 7);
`else
        check("t6_span", span(), 8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
